i4001: RTL and testbench

Mask-ROM responder for the i4004 4-bit multiplexed bus: 256×8 program ROM plus a 4-bit I/O port. It tracks the CPU's 8-phase cycle from PHI1/PHI2/SYNC. It latches the 12-bit address in A1–A3, drives OPR/OPA in M1/M2 when selected, and services SRC/WRR/RDR port accesses in X2. Several instances, each with a distinct CHIP_ID, form the ROM bank behind one `i4004`.

---
 rtl/i4001_pkg.sv | 31 +++
 rtl/i4001_rom.sv | 19 +
 rtl/i4001.sv | 166 ++++++++++++++++
 tb/tb_i4001.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/i4001_pkg.sv
// Shared definitions for the i4001 ROM responder: bus phase encoding (same as
// the CPU) and the opcode fields the ROM has to recognise.
package i4001_pkg;

  typedef enum logic [2:0] {
    STATE_A1 = 3'd0,
    STATE_A2 = 3'd1,
    STATE_A3 = 3'd2,
    STATE_M1 = 3'd3,
    STATE_M2 = 3'd4,
    STATE_X1 = 3'd5,
    STATE_X2 = 3'd6,
    STATE_X3 = 3'd7
  } phase_t;

  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;
  localparam logic [3:0] OPR_IO      = 4'hE;
  localparam logic [3:0] OPA_WRR     = 4'h2;
  localparam logic [3:0] OPA_RDR     = 4'hA;

  // True when this word is followed by an operand word that must not be decoded.
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS) ||
           (opr == OPR_ISZ) || ((opr == OPR_FIM_SRC) && (opa[0] == 1'b0));
  endfunction

endpackage

// File: rtl/i4001_rom.sv
// 256x8 program mask ROM with a registered (one clk) read port.
module i4001_rom #(
  parameter string ROM_FILE = "rom.hex"
) (
  input  logic       clk_i,
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);

  logic [7:0] mem [0:255];
  logic [7:0] data_q;

  always_ff @(posedge clk_i) begin
    data_q <= mem[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/i4001.sv
// i4001 ROM + I/O port responder: follows the i4004 8-phase bus cycle from
// PHI1/PHI2/SYNC, serves instruction fetches and the SRC/WRR/RDR port commands.
module i4001
  import i4001_pkg::*;
#(
  parameter logic [3:0] CHIP_ID  = 4'h0,
  parameter string      ROM_FILE = "rom.hex",
  parameter logic [3:0] IO_MASK  = 4'b1111
) (
  input  logic       clk_i,
  input  logic       RESET_n_i,
  input  logic       PHI1_i,
  input  logic       PHI2_i,
  input  logic       SYNC_i,
  input  logic       CM_ROM_i,
  input  logic [3:0] D_i,
  output logic [3:0] D_o,
  output logic       D_oe_o,
  input  logic [3:0] IO_i,
  output logic [3:0] IO_o
);

  phase_t      phase_q, phase_d;
  logic        phi1_s_q, phi1_p_q, phi2_s_q, phi2_p_q;
  logic        phi1_rise, phi2_rise;
  logic [11:0] addr_q, addr_d;
  logic        sel_q, sel_d;
  logic        io_sel_q, io_sel_d;
  logic        second_q, second_d;
  logic        word2_q, word2_d;
  logic [3:0]  opr_q, opr_d;
  logic [3:0]  opa_q, opa_d;
  logic [3:0]  io_q, io_d;
  logic [3:0]  dout_q, dout_d;
  logic        oe_q, oe_d;
  logic [7:0]  rom_data;
  logic        exec_ok;

  i4001_rom #(.ROM_FILE(ROM_FILE)) u_rom (
    .clk_i  (clk_i),
    .addr_i (addr_q[7:0]),
    .data_o (rom_data)
  );

  // Edge detectors keep tracking during reset so release cannot fake an edge.
  always_ff @(posedge clk_i) begin
    phi1_s_q <= PHI1_i;
    phi1_p_q <= phi1_s_q;
    phi2_s_q <= PHI2_i;
    phi2_p_q <= phi2_s_q;
  end

  assign phi1_rise = phi1_s_q & ~phi1_p_q;
  assign phi2_rise = phi2_s_q & ~phi2_p_q;
  assign exec_ok   = ~word2_q;

  always_comb begin
    phase_d  = phase_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    io_sel_d = io_sel_q;
    second_d = second_q;
    word2_d  = word2_q;
    opr_d    = opr_q;
    opa_d    = opa_q;
    io_d     = io_q;

    if (phi2_rise) begin
      phase_d = SYNC_i ? phase_t'(phase_q + 3'd1) : STATE_A1;
    end else begin
      phase_d = phase_q;
    end

    if (phi1_rise) begin
      case (phase_q)
        STATE_A1: addr_d[3:0] = D_i;
        STATE_A2: addr_d[7:4] = D_i;
        STATE_A3: begin
          addr_d[11:8] = D_i;
          sel_d        = (addr_d[11:8] == CHIP_ID) && CM_ROM_i;
        end
        STATE_M1: opr_d = D_i;
        STATE_M2: begin
          // An operand word is snooped but never decoded as an instruction.
          opa_d    = D_i;
          word2_d  = second_q;
          second_d = ~second_q && is_two_word(opr_q, D_i);
        end
        STATE_X2: begin
          if (exec_ok && (opr_q == OPR_FIM_SRC) && opa_q[0] && CM_ROM_i) begin
            io_sel_d = (D_i == CHIP_ID);
          end else begin
            io_sel_d = io_sel_q;
          end
          if (exec_ok && (opr_q == OPR_IO) && (opa_q == OPA_WRR) && io_sel_q) begin
            io_d = D_i & IO_MASK;
          end else begin
            io_d = io_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    oe_d   = 1'b0;
    dout_d = 4'h0;
    case (phase_q)
      STATE_M1: begin
        oe_d   = sel_q;
        dout_d = sel_q ? rom_data[7:4] : 4'h0;
      end
      STATE_M2: begin
        oe_d   = sel_q;
        dout_d = sel_q ? rom_data[3:0] : 4'h0;
      end
      STATE_X2: begin
        if (exec_ok && io_sel_q && (opr_q == OPR_IO) && (opa_q == OPA_RDR)) begin
          oe_d   = 1'b1;
          dout_d = (IO_i & ~IO_MASK) | (io_q & IO_MASK);
        end else begin
          oe_d   = 1'b0;
          dout_d = 4'h0;
        end
      end
      default: begin
        oe_d   = 1'b0;
        dout_d = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!RESET_n_i) begin
      phase_q  <= STATE_X3;
      addr_q   <= 12'h000;
      sel_q    <= 1'b0;
      io_sel_q <= 1'b0;
      second_q <= 1'b0;
      word2_q  <= 1'b0;
      opr_q    <= 4'h0;
      opa_q    <= 4'h0;
      io_q     <= 4'h0;
      dout_q   <= 4'h0;
      oe_q     <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      io_sel_q <= io_sel_d;
      second_q <= second_d;
      word2_q  <= word2_d;
      opr_q    <= opr_d;
      opa_q    <= opa_d;
      io_q     <= io_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
    end
  end

  assign D_o    = dout_q;
  assign D_oe_o = oe_q;
  assign IO_o   = io_q;

endmodule

// File: tb/tb_i4001.sv
// Bench for i4001: two chips (ID 3 and ID 5) on one emulated i4004 bus,
// checked against a bus-cycle level reference model.
module tb_i4001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       phi1 = 1'b0, phi2 = 1'b0, sync = 1'b0, cm = 1'b0;
  logic [3:0] d_in = 4'h0, io_in = 4'h0;
  logic [3:0] d3, d5, io3, io5;
  logic       oe3, oe5;

  int tests = 0;
  int fails = 0;

  logic [7:0] rom_m [2][256];
  logic [3:0] io_m [2];
  bit         io_sel_m [2];
  bit         pending;
  logic [3:0] mask_m [2];
  logic [3:0] id_m [2];

  always #5 clk = ~clk;

  i4001 #(.CHIP_ID(4'h3), .ROM_FILE(""), .IO_MASK(4'b1111)) u3 (
    .clk_i(clk), .RESET_n_i(rst_n), .PHI1_i(phi1), .PHI2_i(phi2), .SYNC_i(sync),
    .CM_ROM_i(cm), .D_i(d_in), .D_o(d3), .D_oe_o(oe3), .IO_i(io_in), .IO_o(io3));

  i4001 #(.CHIP_ID(4'h5), .ROM_FILE(""), .IO_MASK(4'b0011)) u5 (
    .clk_i(clk), .RESET_n_i(rst_n), .PHI1_i(phi1), .PHI2_i(phi2), .SYNC_i(sync),
    .CM_ROM_i(cm), .D_i(d_in), .D_o(d5), .D_oe_o(oe5), .IO_i(io_in), .IO_o(io5));

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ph2_pulse();
    phi2 = 1'b1;
    repeat (3) @(negedge clk);
    phi2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ph1_pulse();
    phi1 = 1'b1;
    repeat (3) @(negedge clk);
    phi1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic bit two_word(input logic [7:0] w);
    return (w[7:4] == 4'h1) || (w[7:4] == 4'h4) || (w[7:4] == 4'h5) ||
           (w[7:4] == 4'h7) || ((w[7:4] == 4'h2) && !w[0]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      io_m[c]     = 4'h0;
      io_sel_m[c] = 1'b0;
    end
    pending = 1'b0;
  endtask

  // One full instruction cycle as the CPU drives it; optionally reset during M1.
  task automatic run_cycle(input logic [11:0] addr, input logic cm_a3, input logic [7:0] ext_word,
                           input logic [3:0] x2_d, input logic cm_x2, input logic [3:0] pins,
                           input bit abort_m1);
    int         fsel;
    logic [7:0] word;
    bit         skip, rdr, wrr, src;
    logic       exp_oe;
    logic [3:0] exp_d, obs_d, obs_io;
    logic       obs_oe;
    fsel = -1;
    if (cm_a3 && addr[11:8] == id_m[0]) fsel = 0;
    else if (cm_a3 && addr[11:8] == id_m[1]) fsel = 1;
    word = (fsel >= 0) ? rom_m[fsel][addr[7:0]] : ext_word;
    skip = pending;
    rdr  = !skip && (word == 8'hEA);
    wrr  = !skip && (word == 8'hE2);
    src  = !skip && (word[7:4] == 4'h2) && word[0];
    io_in = pins;
    for (int p = 0; p < 8; p++) begin
      ph2_pulse();
      sync = (p == 7) ? 1'b0 : 1'b1;
      for (int c = 0; c < 2; c++) begin
        obs_oe = (c == 0) ? oe3 : oe5;
        obs_d  = (c == 0) ? d3 : d5;
        exp_oe = (((p == 3) || (p == 4)) && (fsel == c)) || ((p == 6) && rdr && io_sel_m[c]);
        exp_d  = (p == 3) ? word[7:4] : (p == 4) ? word[3:0]
               : ((pins & ~mask_m[c]) | (io_m[c] & mask_m[c]));
        check($sformatf("oe chip%0d ph%0d", c, p), {3'b000, obs_oe}, {3'b000, exp_oe});
        if (exp_oe) check($sformatf("d chip%0d ph%0d", c, p), obs_d, exp_d);
      end
      if (abort_m1 && (p == 3)) begin
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        check("rst oe3", {3'b000, oe3}, 4'h0);
        check("rst oe5", {3'b000, oe5}, 4'h0);
        check("rst d3", d3, 4'h0);
        check("rst io3", io3, 4'h0);
        check("rst io5", io5, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sync  = 1'b0;
        cm    = 1'b0;
        return;
      end
      cm = 1'b0;
      case (p)
        0: d_in = addr[3:0];
        1: d_in = addr[7:4];
        2: begin d_in = addr[11:8]; cm = cm_a3; end
        3: d_in = word[7:4];
        4: d_in = word[3:0];
        6: begin d_in = x2_d; cm = cm_x2; end
        default: d_in = 4'($urandom);
      endcase
      ph1_pulse();
      if (p == 6) begin
        for (int c = 0; c < 2; c++) begin
          if (wrr && io_sel_m[c]) io_m[c] = x2_d & mask_m[c];
          if (src && cm_x2) io_sel_m[c] = (x2_d == id_m[c]);
        end
        for (int c = 0; c < 2; c++) begin
          obs_io = (c == 0) ? io3 : io5;
          check($sformatf("io chip%0d", c), obs_io, io_m[c]);
        end
      end
    end
    cm = 1'b0;
    pending = !skip && two_word(word);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] picks [6];
    logic [3:0] hi, xd;
    picks = '{8'h21, 8'hE2, 8'hEA, 8'h40, 8'h20, 8'h00};
    id_m[0] = 4'h3; id_m[1] = 4'h5;
    mask_m[0] = 4'b1111; mask_m[1] = 4'b0011;
    model_reset();

    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom); rom_m[0][i] = b; u3.u_rom.mem[i] = b;
      b = 8'($urandom); rom_m[1][i] = b; u5.u_rom.mem[i] = b;
    end
    rom_m[0][8'h45] = 8'hD7; u3.u_rom.mem[8'h45] = 8'hD7;
    rom_m[0][8'h00] = 8'h40; u3.u_rom.mem[8'h00] = 8'h40;
    rom_m[0][8'h01] = 8'hE2; u3.u_rom.mem[8'h01] = 8'hE2;
    rom_m[0][8'h02] = 8'hE2; u3.u_rom.mem[8'h02] = 8'hE2;

    repeat (3) @(negedge clk);
    check("reset oe3", {3'b000, oe3}, 4'h0);
    check("reset oe5", {3'b000, oe5}, 4'h0);
    check("reset d3", d3, 4'h0);
    check("reset d5", d5, 4'h0);
    check("reset io3", io3, 4'h0);
    check("reset io5", io5, 4'h0);
    rst_n = 1'b1;
    sync  = 1'b0;
    @(negedge clk);

    // Fetch select / non-select.
    run_cycle(12'h345, 1'b1, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0);
    run_cycle(12'h245, 1'b1, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0);
    // SRC chip 3, then JUN + operand 0xE2 (skipped), then a real WRR.
    run_cycle(12'hF00, 1'b0, 8'h21, 4'h3, 1'b1, 4'h0, 1'b0);
    run_cycle(12'h300, 1'b1, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0);
    run_cycle(12'h301, 1'b1, 8'h00, 4'hA, 1'b0, 4'h0, 1'b0);
    run_cycle(12'h302, 1'b1, 8'h00, 4'h6, 1'b0, 4'h0, 1'b0);
    // Port I/O on chip 5 with a partial output mask.
    run_cycle(12'hF10, 1'b0, 8'h21, 4'h5, 1'b1, 4'h0, 1'b0);
    run_cycle(12'hF11, 1'b0, 8'hE2, 4'hF, 1'b0, 4'h0, 1'b0);
    run_cycle(12'hF12, 1'b0, 8'hEA, 4'h0, 1'b0, 4'b1000, 1'b0);
    // Reset during a selected fetch, then a clean fetch after release.
    run_cycle(12'hF20, 1'b0, 8'h21, 4'h3, 1'b1, 4'h0, 1'b0);
    run_cycle(12'hF21, 1'b0, 8'hE2, 4'h9, 1'b0, 4'h0, 1'b0);
    run_cycle(12'h345, 1'b1, 8'h00, 4'h0, 1'b0, 4'h0, 1'b1);
    run_cycle(12'h345, 1'b1, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0);

    for (int n = 0; n < 50; n++) begin
      case ($urandom_range(0, 2))
        0: hi = 4'h3;
        1: hi = 4'h5;
        default: hi = 4'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0: xd = 4'h3;
        1: xd = 4'h5;
        default: xd = 4'($urandom);
      endcase
      b = ($urandom_range(0, 6) == 6) ? 8'($urandom) : picks[$urandom_range(0, 5)];
      run_cycle({hi, 8'($urandom)}, 1'($urandom_range(0, 3) != 0), b, xd,
                1'($urandom), 4'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
